// File: rtl/alu_writeback.sv
// ALU result writeback queue: buffers ALU results with precomputed flags and
// write-enable, delivers them in order to the register file, counts illegal opcodes.
module alu_writeback #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_opcode,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_zero,
  output logic        out_neg,
  output logic [7:0]  err_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        zero;
    logic        neg;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic   push;
  logic   pop;
  logic   illegal_op;
  entry_t new_entry;
  entry_t head;

  assign in_ready   = rst_n && !flush && (count_q < CW'(DEPTH));
  assign out_valid  = rst_n && (count_q != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign illegal_op = (in_opcode >= 5'd16);

  // Flags are captured with the word so they can never drift from out_data.
  always_comb begin
    new_entry.data = in_result;
    new_entry.rd   = in_rd;
    new_entry.we   = !illegal_op && (in_rd != 5'd0);
    new_entry.zero = (in_result == 32'd0);
    new_entry.neg  = in_result[31];
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
        if (illegal_op && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head     = mem_q[rd_ptr_q];
  assign out_data = out_valid ? head.data : 32'd0;
  assign out_rd   = out_valid ? head.rd   : 5'd0;
  assign out_we   = out_valid && head.we;
  assign out_zero = out_valid && head.zero;
  assign out_neg  = out_valid && head.neg;
  assign err_cnt  = err_cnt_q;

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 2, result-queue entries; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous discard of all queued results.
REQ-005 SHALL have port in_valid  input  1  ALU result present.
REQ-006 SHALL have port in_ready  output  1  queue can accept this cycle.
REQ-007 SHALL have port in_result  input  32  ALU output word.
REQ-008 SHALL have port in_opcode  input  5  opcode that produced in_result.
REQ-009 SHALL have port in_rd  input  5  destination register index.
REQ-010 SHALL have port out_valid  output  1  head entry present.
REQ-011 SHALL have port out_ready  input  1  register file consumes head.
REQ-012 SHALL have port out_data  output  32  head result.
REQ-013 SHALL have port out_rd  output  5  head destination.
REQ-014 SHALL have port out_we  output  1  head writes register file.
REQ-015 SHALL have port out_zero  output  1  head result == 0.
REQ-016 SHALL have port out_neg  output  1  head result bit 31.
REQ-017 SHALL have port err_cnt  output  8  illegal-opcode count.

Function
REQ-018 SHALL accept an entry on a rising edge where in_valid=1 and in_ready=1; no other condition writes the queue.
REQ-019 SHALL drive in_ready = (count < DEPTH) and rst_n=1 and flush=0, with no combinational dependence on out_ready.
REQ-020 SHALL, when full, refuse a push even if out_ready=1 in the same cycle (pop occurs, push does not).
REQ-021 SHALL pop the head on a rising edge where out_valid=1 and out_ready=1.
REQ-022 SHALL drive out_valid = (count != 0), registered state only.
REQ-023 SHALL have latency one cycle: entry accepted at edge N appears at head with out_valid=1 after edge N when queue was empty.
REQ-024 SHALL support simultaneous push and pop when 0 < count < DEPTH, count unchanged, order preserved.
REQ-025 SHALL deliver entries strictly in acceptance order; read/write pointers wrap modulo DEPTH.
REQ-026 SHALL compute per entry at acceptance: zero = (in_result == 0), neg = in_result[31], stored with the entry.
REQ-027 SHALL classify in_opcode 0-15 as legal and 16-31 as illegal.
REQ-028 SHALL set stored we = legal and (in_rd != 0); register 0 is never written.
REQ-029 SHALL still queue illegal-opcode entries (we=0) so downstream ordering is preserved.
REQ-030 SHALL increment err_cnt by 1 per accepted illegal-opcode entry, saturating at 255.
REQ-031 SHALL drive out_data, out_rd, out_we, out_zero, out_neg to 0 whenever out_valid=0.
REQ-032 SHALL, on flush=1 at an edge, set count and both pointers to 0, drop any concurrent push/pop, and leave err_cnt unchanged.
REQ-033 SHALL keep in_result storage independent of out_zero/out_neg timing: flags always match out_data of the same entry.

Reset
REQ-034 SHALL, on an edge with rst_n=0, set count, pointers and err_cnt to 0, regardless of in_valid, out_ready or flush.
REQ-035 SHALL hold in_ready=0, out_valid=0 and all out_* data outputs 0 while rst_n=0.
REQ-036 SHALL, on reset mid-operation, discard all queued entries; first edge with rst_n=1 may accept a push.

Verification
REQ-037 Single push: in_result=0x0000_0005, opcode=0, rd=3 at edge 1, out_ready=0 -> after edge 1 out_valid=1, out_data=5, out_rd=3, out_we=1, out_zero=0, out_neg=0.
REQ-038 Fill and stall (DEPTH=2): push 0xAAAA_AAAA then 0x0 with out_ready=0 -> in_ready=0 after 2nd edge; third in_valid ignored; then drain gives 0xAAAA_AAAA (neg=1) then 0x0 (zero=1).
REQ-039 Full with concurrent pop: queue full, in_valid=1, out_ready=1 -> one pop, no push, count=1, in_ready=1 next cycle.
REQ-040 Illegal/r0: push opcode=17 rd=4, then opcode=2 rd=0 -> both delivered with out_we=0; err_cnt=1; 256 further illegal pushes -> err_cnt=255.
REQ-041 Flush and reset: 2 entries queued, flush=1 with in_valid=1 -> out_valid=0, err_cnt unchanged; repeat with rst_n=0 -> out_valid=0, err_cnt=0.
REQ-042 Streaming: in_valid=1, out_ready=1 every cycle for 20 words 1..20 -> outputs 1..20 in order, one per cycle after first-cycle latency, count never exceeds 1.
